// File: rtl/tt_query_driver.sv
// tt_query_driver: initiator side of the shortest-path query protocol.
// Streams a query beat plus a stored edge list, then captures and times the cost.
module tt_query_driver #(
    parameter int EDGE_DEPTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [3:0] cfg_src,
    input  logic [3:0] cfg_dst,
    input  logic [3:0] q_src,
    input  logic [3:0] q_dst,
    input  logic [4:0] edge_cnt,
    input  logic       start,
    output logic       busy,
    output logic       in_valid,
    output logic [3:0] source,
    output logic [3:0] destination,
    input  logic       out_valid,
    input  logic [3:0] cost,
    output logic       done,
    output logic [3:0] result_cost,
    output logic [7:0] result_lat,
    output logic       timeout,
    output logic       spurious_err
);

    typedef enum logic [1:0] {
        IDLE,
        QUERY,
        EDGES,
        WAIT
    } state_t;

    localparam logic [4:0] DEPTH = 5'(EDGE_DEPTH);
    localparam logic [7:0] LAST  = 8'(TIMEOUT - 1);
    localparam logic [7:0] TMAX  = 8'(TIMEOUT);

    state_t     state, state_d;
    logic [7:0] mem [EDGE_DEPTH];
    logic [7:0] rd_entry;
    logic [4:0] cnt, cnt_d;
    logic [4:0] idx, idx_d;
    logic [7:0] wait_cnt, wait_d;
    logic       busy_d, valid_d, done_d, to_d, spur_d;
    logic [3:0] src_d, dst_d, rc_d;
    logic [7:0] rl_d;

    // Edge memory has no reset so a programmed list survives rst.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE)
            mem[cfg_addr] <= {cfg_src, cfg_dst};
    end

    assign rd_entry = mem[idx[3:0]];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        wait_d  = wait_cnt;
        valid_d = 1'b0;
        src_d   = 4'd0;
        dst_d   = 4'd0;
        done_d  = 1'b0;
        to_d    = 1'b0;
        rc_d    = result_cost;
        rl_d    = result_lat;
        spur_d  = spurious_err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = QUERY;
                    valid_d = 1'b1;
                    src_d   = q_src;
                    dst_d   = q_dst;
                    cnt_d   = (edge_cnt > DEPTH) ? DEPTH : edge_cnt;
                    idx_d   = 5'd0;
                    spur_d  = 1'b0;
                end
            end
            QUERY: begin
                if (cnt != 5'd0) begin
                    state_d = EDGES;
                    valid_d = 1'b1;
                    src_d   = rd_entry[7:4];
                    dst_d   = rd_entry[3:0];
                    idx_d   = 5'd1;
                end else begin
                    state_d = WAIT;
                    wait_d  = 8'd0;
                end
            end
            EDGES: begin
                // idx is the entry driven on the next beat
                if (idx == cnt) begin
                    state_d = WAIT;
                    wait_d  = 8'd0;
                end else begin
                    valid_d = 1'b1;
                    src_d   = rd_entry[7:4];
                    dst_d   = rd_entry[3:0];
                    idx_d   = idx + 5'd1;
                end
            end
            WAIT: begin
                if (out_valid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rc_d    = cost;
                    rl_d    = wait_cnt;
                end else if (wait_cnt == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    rc_d    = 4'd0;
                    rl_d    = TMAX;
                end else begin
                    wait_d = wait_cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (out_valid && state != WAIT)
            spur_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            idx          <= 5'd0;
            wait_cnt     <= 8'd0;
            busy         <= 1'b0;
            in_valid     <= 1'b0;
            source       <= 4'd0;
            destination  <= 4'd0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            result_cost  <= 4'd0;
            result_lat   <= 8'd0;
            spurious_err <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            idx          <= idx_d;
            wait_cnt     <= wait_d;
            busy         <= busy_d;
            in_valid     <= valid_d;
            source       <= src_d;
            destination  <= dst_d;
            done         <= done_d;
            timeout      <= to_d;
            result_cost  <= rc_d;
            result_lat   <= rl_d;
            spurious_err <= spur_d;
        end
    end

endmodule

// File: tb/tb_tt_query_driver.sv
// tb_tt_query_driver: directed self-checking bench for tt_query_driver.
// Beats are captured on the falling edge; checks run 1ns after the rising edge.
module tb_tt_query_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0, cfg_src = '0, cfg_dst = '0;
    logic [3:0] q_src = '0, q_dst = '0;
    logic [4:0] edge_cnt = '0;
    logic       start = 1'b0;
    logic       busy, in_valid;
    logic [3:0] source, destination;
    logic       out_valid = 1'b0;
    logic [3:0] cost = '0;
    logic       done, timeout, spurious_err;
    logic [3:0] result_cost;
    logic [7:0] result_lat;

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;
    logic [7:0] beats [$];
    logic [7:0] exp_q [$];

    tt_query_driver dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst),
        .q_src(q_src), .q_dst(q_dst),
        .edge_cnt(edge_cnt), .start(start),
        .busy(busy), .in_valid(in_valid),
        .source(source), .destination(destination),
        .out_valid(out_valid), .cost(cost),
        .done(done), .result_cost(result_cost),
        .result_lat(result_lat), .timeout(timeout),
        .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (in_valid === 1'b1) beats.push_back({source, destination});
        if (done === 1'b1) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beats(input string tag);
        chk({tag, "_n"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i),
                (i < beats.size()) ? {24'd0, beats[i]} : 32'hdead,
                {24'd0, exp_q[i]});
    endtask

    task automatic load(input int a, input logic [3:0] s, input logic [3:0] d);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_src = s; cfg_dst = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic launch(input logic [3:0] s, input logic [3:0] d,
                          input logic [4:0] n);
        beats.delete();
        q_src = s; q_dst = d; edge_cnt = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_wait(input string tag);
        int k = 0;
        while (in_valid !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_wait_bound"}, 32'(k < 100), 32'd1);
    endtask

    task automatic respond(input logic [3:0] c);
        out_valid = 1'b1; cost = c;
        tick();
        out_valid = 1'b0;
    endtask

    initial begin
        int ds;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", in_valid, 0);
        chk("rst_src", source, 0);
        chk("rst_dst", destination, 0);
        chk("rst_done", done, 0);
        chk("rst_cost", result_cost, 0);
        chk("rst_lat", result_lat, 0);
        chk("rst_to", timeout, 0);
        chk("rst_spur", spurious_err, 0);
        rst = 1'b0;
        tick();

        // chain
        load(0, 4'd0, 4'd1); load(1, 4'd1, 4'd2); load(2, 4'd2, 4'd3);
        launch(4'd0, 4'd3, 5'd3);
        chk("t1_busy", busy, 1);
        chk("t1_qvalid", in_valid, 1);
        wait_wait("t1");
        exp_q = '{8'h03, 8'h01, 8'h12, 8'h23};
        chk_beats("t1");
        chk("t1_wait_busy", busy, 1);
        tick();
        chk("t1_pre_done", done, 0);
        respond(4'd3);
        chk("t1_done", done, 1);
        chk("t1_cost", result_cost, 3);
        chk("t1_lat", result_lat, 1);
        chk("t1_to", timeout, 0);
        chk("t1_busy_fall", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_hold", result_cost, 3);

        // zero edges
        launch(4'd5, 4'd9, 5'd0);
        wait_wait("t2");
        exp_q = '{8'h59};
        chk_beats("t2");
        respond(4'd0);
        chk("t2_done", done, 1);
        chk("t2_cost", result_cost, 0);
        chk("t2_lat", result_lat, 0);
        tick();

        // timeout
        launch(4'd2, 4'd4, 5'd2);
        wait_wait("t3");
        for (int i = 0; i < 63; i++) tick();
        chk("t3_early_done", done, 0);
        chk("t3_early_busy", busy, 1);
        tick();
        chk("t3_done", done, 1);
        chk("t3_to", timeout, 1);
        chk("t3_cost", result_cost, 0);
        chk("t3_lat", result_lat, 64);
        chk("t3_busy", busy, 0);
        tick();
        chk("t3_to_pulse", timeout, 0);

        // clamp + busy rules
        for (int i = 0; i < 16; i++) load(i, 4'(i), 4'(15 - i));
        launch(4'hA, 4'hB, 5'd20);
        tick(); tick(); tick(); tick();
        start = 1'b1; q_src = 4'h1; q_dst = 4'h1;
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_src = 4'hF; cfg_dst = 4'hF;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        wait_wait("t4");
        exp_q = '{8'hAB};
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 4'(15 - i)});
        chk_beats("t4");
        respond(4'd5);
        chk("t4_done", done, 1);
        chk("t4_cost", result_cost, 5);
        tick();
        chk("t4_no_queue", busy, 0);
        chk("t4_idle_valid", in_valid, 0);

        // spurious response
        launch(4'd1, 4'd2, 5'd4);
        tick();
        out_valid = 1'b1; cost = 4'd9;
        tick();
        out_valid = 1'b0;
        chk("t5_spur", spurious_err, 1);
        wait_wait("t5");
        exp_q = '{8'h12, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
        chk_beats("t5");
        respond(4'd7);
        chk("t5_done", done, 1);
        chk("t5_cost", result_cost, 7);
        chk("t5_lat", result_lat, 0);
        chk("t5_sticky", spurious_err, 1);
        tick();

        // reset mid-EDGES, then replay
        launch(4'd6, 4'd7, 5'd5);
        chk("t6_spur_clr", spurious_err, 0);
        tick(); tick(); tick();
        chk("t6_beat2", {source, destination}, 8'h2D);
        ds = done_seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", in_valid, 0);
        chk("t6_rst_busy", busy, 0);
        tick(); tick(); tick();
        chk("t6_no_done", done_seen, ds);
        launch(4'd6, 4'd7, 5'd5);
        wait_wait("t6");
        exp_q = '{8'h67, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B};
        chk_beats("t6");
        tick();
        respond(4'd2);
        chk("t6_done", done, 1);
        chk("t6_cost", result_cost, 2);
        chk("t6_lat", result_lat, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tt_query_driver.md
Name: tt_query_driver

Overview:
- Initiator side of the shortest-path query protocol (query beat, then edge beats, then a single-cycle cost response).
- Stores a programmable edge list and a query pair. On `start`, streams them onto `in_valid`/`source`/`destination`. Then waits for `out_valid`, captures `cost` and reports it with a response latency.
- Used as the on-chip stimulus engine in front of the path-cost solver, and as a self-test source.

Parameters:
- EDGE_DEPTH, 16, number of edge-list entries; addressed by `cfg_addr`.
- TIMEOUT, 64, maximum WAIT cycles before the transaction is aborted with `timeout`.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  write the edge-list entry at `cfg_addr`.
- cfg_addr  in  4  edge-list index.
- cfg_src  in  4  edge endpoint A.
- cfg_dst  in  4  edge endpoint B.
- q_src  in  4  query source node; sampled on an accepted `start`.
- q_dst  in  4  query destination node; sampled on an accepted `start`.
- edge_cnt  in  5  number of edges to send (0..16); sampled on an accepted `start`.
- start  in  1  launch a transaction; accepted only in IDLE.
- busy  out  1  high in every state except IDLE.
- in_valid  out  1  protocol beat valid (to solver).
- source  out  4  beat field A (to solver).
- destination  out  4  beat field B (to solver).
- out_valid  in  1  solver response strobe.
- cost  in  4  solver path cost; 0 = unreachable.
- done  out  1  one-cycle pulse: result fields updated.
- result_cost  out  4  captured cost.
- result_lat  out  8  WAIT cycles elapsed before `out_valid` was seen.
- timeout  out  1  one-cycle pulse, coincident with `done` on abort.
- spurious_err  out  1  sticky: `out_valid` seen outside WAIT.

Behaviour:
- All outputs registered. Reset values: `busy`, `in_valid`, `source`, `destination`, `done`, `result_cost`, `result_lat`, `timeout`, `spurious_err` all 0. FSM goes to IDLE.
- Edge memory is not reset; contents survive `rst`.
- `cfg_we` is honoured only in IDLE; ignored while busy.
- Edge memory: entry i holds {A, B}.
- FSM states and transitions:
  - IDLE: `start` accepted at cycle t. Latch `q_src`, `q_dst`, and `min(edge_cnt, EDGE_DEPTH)`. Clear `spurious_err`. Go to QUERY.
  - QUERY: one cycle. Outputs from cycle t+1: `in_valid`=1, `source`=`q_src`, `destination`=`q_dst`. Next is EDGES if count>0, else WAIT.
  - EDGES: one beat per cycle, no gaps. Beat k drives entry k for k=0..count-1. `in_valid` is therefore high for exactly 1+count consecutive cycles. After the last beat go to WAIT.
  - WAIT:
    - Outputs: `in_valid`=0, `source`=`destination`=0.
    - `wait_cnt` clears on entry and increments each WAIT cycle without `out_valid`; first WAIT cycle has `wait_cnt`=0.
    - On `out_valid`=1: `result_cost`<=`cost`, `result_lat`<=`wait_cnt`, `done` pulses next cycle, go to IDLE.
    - If `wait_cnt`==TIMEOUT-1 with no `out_valid`: `result_cost`<=0, `result_lat`<=TIMEOUT, `done` and `timeout` pulse, go to IDLE.
    - `out_valid` and the timeout in the same cycle: the response wins (no `timeout`).
- `busy` falls in the same cycle `done` pulses. A `start` in that cycle is accepted (back-to-back transactions allowed).
- `start` while busy: ignored, not queued.
- `out_valid` in IDLE, QUERY or EDGES: set `spurious_err`; the response is not captured. The sticky flag clears only on `rst` or an accepted `start`.
- `q_src`==`q_dst` and duplicate or self-loop edges are sent verbatim; no filtering.
- `rst` mid-transaction: `in_valid` is 0 from the next cycle, FSM goes to IDLE, no `done`.
- `result_cost` and `result_lat` hold until the next `done`.

Test Plan:
1. Chain: load edges (0,1),(1,2),(2,3), count=3, query 0->3, model responds `out_valid` with cost=3 on the 2nd WAIT cycle. Required: `in_valid` high 4 cycles; beats (0,3),(0,1),(1,2),(2,3); `done` pulse; `result_cost`=3; `result_lat`=1.
2. Zero edges: count=0, query 5->9, model responds cost=0 on the first WAIT cycle. Required: exactly one beat (5,9); `result_cost`=0; `result_lat`=0.
3. Timeout: count=2, no response. Required: `done` and `timeout` pulse together after 64 WAIT cycles; `result_cost`=0; `result_lat`=64; `busy` falls.
4. Clamp and busy rules: `edge_cnt`=20, all 16 entries loaded. Required: 17 beats. A `start` and a `cfg_we` issued mid-EDGES are ignored and memory is unchanged.
5. Spurious response: `out_valid` pulsed during EDGES, then cost=7 in WAIT. Required: `spurious_err`=1 sticky; `result_cost`=7; the next `start` clears `spurious_err`.
6. Reset mid-EDGES: assert `rst` for 1 cycle at beat 2. Required: `in_valid`=0 the next cycle; no `done`. A subsequent `start` replays the preserved edge list correctly.
